// File: rtl/fg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fg_pkg
// Description : Types and constants shared by the func_gen block and its
//               configuration controller: waveform selector, count limits,
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fg_pkg;

   // Waveform selector, also consumed by func_gen
   typedef enum logic [1:0] {
      SINE     = 2'd0,
      TRIANGLE = 2'd1,
      SQUARE   = 2'd2,
      PWM      = 2'd3
   } signal_t;

   // ROM-based waveforms have a smaller legal period divider than the
   // pulse waveforms, which need no table
   localparam int unsigned MAX_COUNT_ROM   = 9999;
   localparam int unsigned MAX_COUNT_PULSE = 499999;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SWEEP   = 2'd2
   } ctrl_state_t;

   // True for waveforms limited by MAX_COUNT_PULSE
   function automatic logic is_pulse_type(input signal_t t);
      return (t == SQUARE) || (t == PWM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fg_sweep_step.sv
`default_nettype none
// ============================================================================
// Module      : fg_sweep_step
// Description : Combinational next-count calculator for the linear frequency
//               sweep. Steps the current count toward stop, clamps at stop,
//               and reloads start once stop has been reached (sawtooth).
// Ports       : cur        - current set_count
//               start      - sweep start count (reload value)
//               stop       - sweep end count
//               step       - step magnitude
//               up         - 1: counting up toward stop, 0: counting down
//               next_count - value set_count takes at the step point
// Revision    : 1.0 - initial release
// ============================================================================
module fg_sweep_step (
   input  logic [31:0] cur,
   input  logic [31:0] start,
   input  logic [31:0] stop,
   input  logic [15:0] step,
   input  logic        up,
   output logic [31:0] next_count
);
   import fg_pkg::*;

   // 33-bit arithmetic so neither direction can wrap
   logic [32:0] w_sum;
   logic [32:0] w_floor;
   logic [32:0] w_diff;

   assign w_sum   = {1'b0, cur}  + {17'b0, step};
   assign w_diff  = {1'b0, cur}  - {17'b0, step};
   // cur - step < stop  is evaluated as  cur < stop + step  to avoid borrow
   assign w_floor = {1'b0, stop} + {17'b0, step};

   always_comb begin
      next_count = cur;
      if (cur == stop) begin
         next_count = start;
      end else if (up) begin
         next_count = (w_sum > {1'b0, stop}) ? stop : w_sum[31:0];
      end else begin
         next_count = ({1'b0, cur} < w_floor) ? stop : w_diff[31:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/fg_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fg_config_ctrl
// Description : Configuration sequencer in front of func_gen. Accepts and
//               range-checks requests over valid/ready, applies them only at a
//               waveform period boundary (or after a timeout), and runs an
//               optional sawtooth frequency sweep on set_count.
// Ports       : clk, rst_n            - clock, async active-low reset
//               cfg_valid/cfg_ready   - request handshake
//               cfg_sig_type/count/duty, cfg_sweep_* - request payload
//               period_tick           - period boundary pulse from func_gen
//               set_count/sig_type/duty_cycle - settings to func_gen
//               cfg_err               - one-cycle pulse on rejected request
//               pending               - accepted config awaiting boundary
//               sweep_active          - sweep running
// Revision    : 1.0 - initial release
// ============================================================================
module fg_config_ctrl #(
   parameter int unsigned DEFAULT_COUNT   = 999,
   parameter int unsigned MAX_COUNT_ROM   = fg_pkg::MAX_COUNT_ROM,
   parameter int unsigned MAX_COUNT_PULSE = fg_pkg::MAX_COUNT_PULSE,
   parameter int unsigned TIMEOUT         = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [1:0]  cfg_sig_type,
   input  logic [31:0] cfg_count,
   input  logic [7:0]  cfg_duty,
   input  logic        cfg_sweep_en,
   input  logic [31:0] cfg_sweep_stop,
   input  logic [15:0] cfg_sweep_step,
   input  logic [7:0]  cfg_sweep_dwell,
   input  logic        period_tick,
   output logic [31:0] set_count,
   output logic [1:0]  sig_type,
   output logic [7:0]  duty_cycle,
   output logic        cfg_err,
   output logic        pending,
   output logic        sweep_active
);
   import fg_pkg::*;

   localparam logic [31:0] c_default_count = 32'(DEFAULT_COUNT);
   localparam logic [31:0] c_limit_rom     = 32'(MAX_COUNT_ROM);
   localparam logic [31:0] c_limit_pulse   = 32'(MAX_COUNT_PULSE);
   localparam logic [31:0] c_tmo_last      = 32'(TIMEOUT - 1);
   localparam logic [7:0]  c_reset_duty    = 8'd128;

   ctrl_state_t r_state;

   // Output registers
   logic [31:0] r_set_count;
   logic [1:0]  r_sig_type;
   logic [7:0]  r_duty;
   logic        r_cfg_err;
   logic        r_pending;
   logic        r_sweep_active;

   // Shadow copy of the accepted request
   logic [1:0]  r_sh_sig;
   logic [31:0] r_sh_count;
   logic [7:0]  r_sh_duty;
   logic        r_sh_sweep_en;
   logic [31:0] r_sh_stop;
   logic [15:0] r_sh_step;
   logic [7:0]  r_sh_dwell;
   logic        r_sh_up;

   logic [31:0] r_tmo;
   logic [7:0]  r_dwell_cnt;

   logic        w_xfer;
   logic [31:0] w_limit;
   logic        w_cfg_ok;
   logic        w_apply;
   logic [7:0]  w_dwell_eff;
   logic        w_dwell_hit;
   logic [31:0] w_next_count;

   assign cfg_ready = (r_state != PENDING);
   assign w_xfer    = cfg_valid && cfg_ready;

   assign w_limit  = is_pulse_type(signal_t'(cfg_sig_type)) ? c_limit_pulse : c_limit_rom;
   assign w_cfg_ok = (cfg_count <= w_limit) &&
                     (!cfg_sweep_en || ((cfg_sweep_stop <= w_limit) &&
                                        (cfg_sweep_step != 16'd0) &&
                                        (cfg_sweep_stop != cfg_count)));

   assign w_apply = (r_state == PENDING) && (period_tick || (r_tmo == c_tmo_last));

   // A dwell of zero behaves as one period per step
   assign w_dwell_eff = (r_sh_dwell == 8'd0) ? 8'd1 : r_sh_dwell;
   assign w_dwell_hit = ({1'b0, r_dwell_cnt} + 9'd1) >= {1'b0, w_dwell_eff};

   fg_sweep_step u_sweep_step (
      .cur        (r_set_count),
      .start      (r_sh_count),
      .stop       (r_sh_stop),
      .step       (r_sh_step),
      .up         (r_sh_up),
      .next_count (w_next_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_set_count    <= c_default_count;
         r_sig_type     <= SINE;
         r_duty         <= c_reset_duty;
         r_cfg_err      <= 1'b0;
         r_pending      <= 1'b0;
         r_sweep_active <= 1'b0;
         r_sh_sig       <= SINE;
         r_sh_count     <= '0;
         r_sh_duty      <= '0;
         r_sh_sweep_en  <= 1'b0;
         r_sh_stop      <= '0;
         r_sh_step      <= '0;
         r_sh_dwell     <= '0;
         r_sh_up        <= 1'b0;
         r_tmo          <= '0;
         r_dwell_cnt    <= '0;
      end else begin
         r_cfg_err <= w_xfer && !w_cfg_ok;

         case (r_state)
            IDLE, SWEEP: begin
               if (w_xfer && w_cfg_ok) begin
                  // A new request pre-empts any sweep; outputs hold until apply
                  r_sh_sig       <= cfg_sig_type;
                  r_sh_count     <= cfg_count;
                  r_sh_duty      <= cfg_duty;
                  r_sh_sweep_en  <= cfg_sweep_en;
                  r_sh_stop      <= cfg_sweep_stop;
                  r_sh_step      <= cfg_sweep_step;
                  r_sh_dwell     <= cfg_sweep_dwell;
                  r_sh_up        <= (cfg_sweep_stop > cfg_count);
                  r_tmo          <= '0;
                  r_pending      <= 1'b1;
                  r_sweep_active <= 1'b0;
                  r_state        <= PENDING;
               end else if ((r_state == SWEEP) && period_tick) begin
                  if (w_dwell_hit) begin
                     r_dwell_cnt <= '0;
                     r_set_count <= w_next_count;
                  end else begin
                     r_dwell_cnt <= r_dwell_cnt + 8'd1;
                  end
               end
            end

            PENDING: begin
               if (w_apply) begin
                  r_set_count    <= r_sh_count;
                  r_sig_type     <= r_sh_sig;
                  r_duty         <= r_sh_duty;
                  r_pending      <= 1'b0;
                  r_sweep_active <= r_sh_sweep_en;
                  r_dwell_cnt    <= '0;
                  r_state        <= r_sh_sweep_en ? SWEEP : IDLE;
               end else begin
                  r_tmo <= r_tmo + 32'd1;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign set_count    = r_set_count;
   assign sig_type     = r_sig_type;
   assign duty_cycle   = r_duty;
   assign cfg_err      = r_cfg_err;
   assign pending      = r_pending;
   assign sweep_active = r_sweep_active;

endmodule
`default_nettype wire

// File: tb/tb_fg_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fg_config_ctrl
// Description : Directed self-checking bench for fg_config_ctrl: reset state,
//               boundary-aligned apply, rejection, up/down sweeps, sweep
//               pre-emption, forced apply on timeout, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fg_config_ctrl;

   localparam logic [1:0] c_sine = 2'd0;
   localparam logic [1:0] c_tri  = 2'd1;
   localparam logic [1:0] c_sq   = 2'd2;
   localparam logic [1:0] c_pwm  = 2'd3;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_sig_type;
   logic [31:0] cfg_count;
   logic [7:0]  cfg_duty;
   logic        cfg_sweep_en;
   logic [31:0] cfg_sweep_stop;
   logic [15:0] cfg_sweep_step;
   logic [7:0]  cfg_sweep_dwell;
   logic        period_tick;
   logic [31:0] set_count;
   logic [1:0]  sig_type;
   logic [7:0]  duty_cycle;
   logic        cfg_err;
   logic        pending;
   logic        sweep_active;

   int checks = 0;
   int errors = 0;

   fg_config_ctrl #(
      .DEFAULT_COUNT   (999),
      .MAX_COUNT_ROM   (9999),
      .MAX_COUNT_PULSE (499999),
      .TIMEOUT         (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_sig_type    (cfg_sig_type),
      .cfg_count       (cfg_count),
      .cfg_duty        (cfg_duty),
      .cfg_sweep_en    (cfg_sweep_en),
      .cfg_sweep_stop  (cfg_sweep_stop),
      .cfg_sweep_step  (cfg_sweep_step),
      .cfg_sweep_dwell (cfg_sweep_dwell),
      .period_tick     (period_tick),
      .set_count       (set_count),
      .sig_type        (sig_type),
      .duty_cycle      (duty_cycle),
      .cfg_err         (cfg_err),
      .pending         (pending),
      .sweep_active    (sweep_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One clock edge; returns 1 time unit after it so outputs are settled
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      period_tick = 1'b1;
      step();
      period_tick = 1'b0;
   endtask

   task automatic send(input logic [1:0] st, input logic [31:0] cnt, input logic [7:0] duty,
                       input logic sw_en, input logic [31:0] stop, input logic [15:0] stp,
                       input logic [7:0] dwell, input logic with_tick);
      cfg_valid       = 1'b1;
      cfg_sig_type    = st;
      cfg_count       = cnt;
      cfg_duty        = duty;
      cfg_sweep_en    = sw_en;
      cfg_sweep_stop  = stop;
      cfg_sweep_step  = stp;
      cfg_sweep_dwell = dwell;
      period_tick     = with_tick;
      step();
      cfg_valid       = 1'b0;
      period_tick     = 1'b0;
   endtask

   // Up-sweep 100->130 step 15 dwell 2, value after each of 12 ticks
   logic [31:0] up_seq [12] = '{100, 115, 115, 130, 130, 100, 100, 115, 115, 130, 130, 100};

   initial begin
      rst_n = 1'b0;
      cfg_valid = 1'b0; cfg_sig_type = '0; cfg_count = '0; cfg_duty = '0;
      cfg_sweep_en = 1'b0; cfg_sweep_stop = '0; cfg_sweep_step = '0;
      cfg_sweep_dwell = '0; period_tick = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();

      // Reset state
      check("rst_count", set_count, 999);
      check("rst_sig", 32'(sig_type), 0);
      check("rst_duty", 32'(duty_cycle), 128);
      check("rst_ready", 32'(cfg_ready), 1);
      check("rst_pending", 32'(pending), 0);
      check("rst_sweep", 32'(sweep_active), 0);
      check("rst_err", 32'(cfg_err), 0);

      // SQUARE 4999 held until the period boundary
      send(c_sq, 4999, 128, 1'b0, 0, 0, 0, 1'b0);
      check("sq_pending", 32'(pending), 1);
      check("sq_ready_low", 32'(cfg_ready), 0);
      repeat (5) step();
      check("sq_hold_count", set_count, 999);
      check("sq_hold_sig", 32'(sig_type), 0);
      check("sq_hold_pending", 32'(pending), 1);
      tick();
      check("sq_apply_count", set_count, 4999);
      check("sq_apply_sig", 32'(sig_type), 2);
      check("sq_apply_pending", 32'(pending), 0);
      check("sq_apply_ready", 32'(cfg_ready), 1);

      // Over-limit SINE rejected with a single-cycle error
      send(c_sine, 10000, 7, 1'b0, 0, 0, 0, 1'b0);
      check("rej_err", 32'(cfg_err), 1);
      check("rej_count", set_count, 4999);
      check("rej_ready", 32'(cfg_ready), 1);
      check("rej_pending", 32'(pending), 0);
      step();
      check("rej_err_clear", 32'(cfg_err), 0);

      // Sweep with zero step rejected
      send(c_tri, 100, 128, 1'b1, 200, 0, 1, 1'b0);
      check("rej_step0_err", 32'(cfg_err), 1);
      check("rej_step0_pend", 32'(pending), 0);

      // Upper limit on a ROM waveform accepted
      send(c_sine, 9999, 128, 1'b0, 0, 0, 0, 1'b0);
      check("lim_accept_err", 32'(cfg_err), 0);
      tick();
      check("lim_accept_count", set_count, 9999);

      // Sweep TRIANGLE 100 -> 130, step 15, dwell 2
      send(c_tri, 100, 128, 1'b1, 130, 15, 2, 1'b0);
      tick();
      check("sw_start_count", set_count, 100);
      check("sw_start_sig", 32'(sig_type), 1);
      check("sw_active", 32'(sweep_active), 1);
      for (int i = 0; i < 12; i++) begin
         tick();
         step();
         check($sformatf("sw_up_%0d", i + 1), set_count, up_seq[i]);
      end

      // Pre-empt the sweep with a coincident tick; dwell counter is at 1
      tick();
      send(c_pwm, 200, 64, 1'b0, 0, 0, 0, 1'b1);
      check("pre_sweep_off", 32'(sweep_active), 0);
      check("pre_no_step", set_count, 100);
      check("pre_pending", 32'(pending), 1);
      step();
      tick();
      check("pre_apply_count", set_count, 200);
      check("pre_apply_sig", 32'(sig_type), 3);
      check("pre_apply_duty", 32'(duty_cycle), 64);

      // No tick: forced apply 16 cycles after acceptance
      send(c_sine, 500, 10, 1'b0, 0, 0, 0, 1'b0);
      repeat (15) step();
      check("tmo_hold_count", set_count, 200);
      check("tmo_hold_pending", 32'(pending), 1);
      step();
      check("tmo_apply_count", set_count, 500);
      check("tmo_apply_duty", 32'(duty_cycle), 10);
      check("tmo_apply_pending", 32'(pending), 0);

      // Down sweep 50 -> 20 step 20, dwell 0 acts as 1, clamps at stop
      send(c_sine, 50, 128, 1'b1, 20, 20, 0, 1'b0);
      tick();
      check("dn_start", set_count, 50);
      tick();
      check("dn_step1", set_count, 30);
      tick();
      check("dn_clamp", set_count, 20);
      tick();
      check("dn_reload", set_count, 50);

      // Rejected request during sweep leaves the sweep running
      send(c_sine, 10000, 0, 1'b0, 0, 0, 0, 1'b1);
      check("dn_rej_err", 32'(cfg_err), 1);
      check("dn_rej_step", set_count, 30);
      check("dn_rej_active", 32'(sweep_active), 1);

      // Reset while pending discards the shadow request
      send(c_sq, 3000, 99, 1'b0, 0, 0, 0, 1'b0);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("arst_count", set_count, 999);
      check("arst_pending", 32'(pending), 0);
      check("arst_sig", 32'(sig_type), 0);
      check("arst_duty", 32'(duty_cycle), 128);
      step();
      rst_n = 1'b1;
      step();
      tick();
      check("arst_discard", set_count, 999);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
